commit_retire_unit: RTL
=======================

# commit_retire_unit

Retire stage directly downstream of the reorder buffer. It consumes the in-order commit stream and does three things:
- returns the physical register of each retired non-store instruction to the free list;
- queues retired stores in a committed-store FIFO and drains them to the memory interface with a valid/ready handshake;
- completes fence requests once all committed stores have drained.

## Interface
- TAG_WIDTH, 6, width of tags and physical register indices (matches ROB)
- SQ_DEPTH, 8, committed-store FIFO entries (power of two, ≥2)
- CNT_WIDTH, 32, width of performance counters

- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- commit_valid  in  1  retiring instruction present this cycle (from ROB)
- commit_tag  in  TAG_WIDTH  ROB tag of retiring instruction
- commit_phys_reg  in  TAG_WIDTH  physical register of retiring instruction
- commit_is_load  in  1  retiring instruction is a load
- commit_is_store  in  1  retiring instruction is a store
- commit_ready  out  1  producer may present a commit next cycle
- free_valid  out  1  free_phys_reg is released this cycle
- free_phys_reg  out  TAG_WIDTH  register returned to free list
- mem_st_valid  out  1  committed store presented to memory
- mem_st_ready  in  1  memory accepts presented store
- mem_st_tag  out  TAG_WIDTH  tag of presented store
- mem_st_phys_reg  out  TAG_WIDTH  data source register of presented store
- fence_req  in  1  one-cycle pulse requesting a store drain
- fence_done  out  1  one-cycle pulse: fence complete
- sq_count  out  $clog2(SQ_DEPTH)+1  FIFO occupancy
- overflow_err  out  1  sticky: commit store arrived with FIFO full
- retired_count, retired_load_count, retired_store_count  out  CNT_WIDTH each  performance counters

## Operation
- Commit acceptance: every cycle with commit_valid=1 retires one instruction. No handshake on input; commit_ready is advisory.
- commit_ready = (free FIFO slots ≥ 2). The one slot of slack absorbs a commit already registered in the ROB.
- Non-store commit with commit_phys_reg ≠ 0: register it for release. Register 0 is never freed.
- Store commit: push {tag, phys_reg} to FIFO. No free is generated.
- Store commit with FIFO full (after same-cycle pop considered): entry dropped, overflow_err set. Cleared only by rst.
- Drain FSM states:
  - IDLE: mem_st_valid=0. If FIFO non-empty, load head into output regs and go to SEND.
  - SEND: mem_st_valid=1; tag/phys_reg held stable while mem_st_ready=0. On mem_st_ready=1, pop head. If FIFO still holds ≥1 entry after the pop, load the next entry and stay in SEND (back-to-back). Otherwise go to IDLE.
- Entry in SEND output regs is counted in sq_count until popped.
- Simultaneous push and pop: sq_count unchanged; pointers wrap modulo SQ_DEPTH.
- Fence:
  - fence_req sets fence_pending.
  - When fence_pending=1 and sq_count=0 and no store commit in this cycle, pulse fence_done and clear fence_pending.
  - fence_req arriving with FIFO already empty → fence_done next cycle.
  - A second fence_req while pending merges; one fence_done.
- Counters increment by 1 per commit (load/store counters by kind) and wrap at 2^CNT_WIDTH.

## Timing
- Reset values: commit_ready=1, free_valid=0, free_phys_reg=0, mem_st_valid=0, mem_st_tag=0, mem_st_phys_reg=0, fence_done=0, sq_count=0, overflow_err=0, all counters 0, FSM=IDLE, fence_pending=0.
- All outputs registered except commit_ready, which is combinational from sq_count.
- Commit at cycle N:
  - free_valid/free_phys_reg at N+1 for one cycle.
  - A store is visible in sq_count at N+1.
  - If the FSM is IDLE, mem_st_valid rises at N+2.
- Handshake completes on a cycle with mem_st_valid & mem_st_ready. The next entry is presented at the following cycle with no bubble.
- rst mid-transfer: FIFO contents discarded, mem_st_valid=0 next cycle, pending fence dropped.

## Configuration
- RETIRE_PERF_CNT_EN defined: retired_count, retired_load_count and retired_store_count are implemented as described.
- RETIRE_PERF_CNT_EN undefined: the counter registers are absent and those outputs are tied to 0.
- All other behaviour is identical with or without the macro.

## Test plan
- Reset, then commit non-store tag=3, phys_reg=17 → free_valid=1, free_phys_reg=17 exactly one cycle later; retired_count=1.
- Commit non-store with phys_reg=0 → no free_valid; counter still increments.
- 3 back-to-back store commits with mem_st_ready=1 → mem_st_valid high 3 consecutive cycles starting 2 cycles after the first commit, tags in order; sq_count returns to 0.
- mem_st_ready=0; commit SQ_DEPTH=8 stores:
  - commit_ready falls when sq_count reaches 7;
  - a 9th store sets overflow_err=1;
  - mem_st_tag stays on the first tag until ready rises.
- 2 stores queued with mem_st_ready=0, fence_req pulse → fence_done stays 0; release ready → fence_done pulses once, the cycle after sq_count reaches 0.
- Assert rst while in SEND with 4 queued → next cycle mem_st_valid=0, sq_count=0, FSM IDLE, overflow_err=0.

Source files
------------

// File: rtl/commit_retire_unit.sv
// Retire stage: frees physical registers, drains committed stores to memory, completes fences.
// Define RETIRE_PERF_CNT_EN to build the retired-instruction performance counters.
module commit_retire_unit #(
   parameter int unsigned TAG_WIDTH = 6,
   parameter int unsigned SQ_DEPTH  = 8,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        commit_valid,
   input  logic [TAG_WIDTH-1:0]        commit_tag,
   input  logic [TAG_WIDTH-1:0]        commit_phys_reg,
   input  logic                        commit_is_load,
   input  logic                        commit_is_store,
   output logic                        commit_ready,
   output logic                        free_valid,
   output logic [TAG_WIDTH-1:0]        free_phys_reg,
   output logic                        mem_st_valid,
   input  logic                        mem_st_ready,
   output logic [TAG_WIDTH-1:0]        mem_st_tag,
   output logic [TAG_WIDTH-1:0]        mem_st_phys_reg,
   input  logic                        fence_req,
   output logic                        fence_done,
   output logic [$clog2(SQ_DEPTH):0]   sq_count,
   output logic                        overflow_err,
   output logic [CNT_WIDTH-1:0]        retired_count,
   output logic [CNT_WIDTH-1:0]        retired_load_count,
   output logic [CNT_WIDTH-1:0]        retired_store_count
);

   localparam int unsigned PW = $clog2(SQ_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {StIdle, StSend} state_e;

   state_e                 state_q;
   logic [2*TAG_WIDTH-1:0] mem [SQ_DEPTH];
   logic [PW-1:0]          wr_ptr_q, rd_ptr_q, rd_ptr_p1;
   logic [CW-1:0]          count_d;
   logic [2*TAG_WIDTH-1:0] head, next_entry;
   logic                   store_commit, full, pop, push, free_hit;
   logic                   fence_pending_q, fence_hit;

   assign store_commit = commit_valid & commit_is_store;
   assign full         = (sq_count == CW'(SQ_DEPTH));
   assign pop          = (state_q == StSend) & mem_st_ready;
   assign push         = store_commit & (~full | pop);
   assign free_hit     = commit_valid & ~commit_is_store & (commit_phys_reg != '0);
   assign commit_ready = (sq_count <= CW'(SQ_DEPTH - 2));
   assign rd_ptr_p1    = rd_ptr_q + 1'b1;
   assign head         = mem[rd_ptr_q];
   // With only the departing entry queued, a same-cycle store is forwarded straight to the output.
   assign next_entry   = (sq_count >= CW'(2)) ? mem[rd_ptr_p1] : {commit_tag, commit_phys_reg};
   assign fence_hit    = (fence_pending_q | fence_req) & (sq_count == '0) & ~store_commit;

   always_comb begin
      count_d = sq_count;
      if (push && !pop) begin
         count_d = sq_count + 1'b1;
      end else if (pop && !push) begin
         count_d = sq_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {commit_tag, commit_phys_reg};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         sq_count        <= '0;
         overflow_err    <= 1'b0;
         free_valid      <= 1'b0;
         free_phys_reg   <= '0;
         mem_st_valid    <= 1'b0;
         mem_st_tag      <= '0;
         mem_st_phys_reg <= '0;
         fence_pending_q <= 1'b0;
         fence_done      <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_p1;
         sq_count <= count_d;
         if (store_commit && full && !pop) overflow_err <= 1'b1;
         free_valid <= free_hit;
         if (free_hit) free_phys_reg <= commit_phys_reg;
         fence_done      <= fence_hit;
         fence_pending_q <= (fence_pending_q | fence_req) & ~fence_hit;
         unique case (state_q)
            StIdle: begin
               if (sq_count != '0) begin
                  state_q         <= StSend;
                  mem_st_valid    <= 1'b1;
                  mem_st_tag      <= head[2*TAG_WIDTH-1:TAG_WIDTH];
                  mem_st_phys_reg <= head[TAG_WIDTH-1:0];
               end
            end
            StSend: begin
               if (mem_st_ready) begin
                  if (count_d != '0) begin
                     mem_st_tag      <= next_entry[2*TAG_WIDTH-1:TAG_WIDTH];
                     mem_st_phys_reg <= next_entry[TAG_WIDTH-1:0];
                  end else begin
                     state_q      <= StIdle;
                     mem_st_valid <= 1'b0;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef RETIRE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_count       <= '0;
         retired_load_count  <= '0;
         retired_store_count <= '0;
      end else if (commit_valid) begin
         retired_count <= retired_count + 1'b1;
         if (commit_is_load) retired_load_count <= retired_load_count + 1'b1;
         if (commit_is_store) retired_store_count <= retired_store_count + 1'b1;
      end
   end
`else
   logic unused_is_load;
   assign unused_is_load      = commit_is_load;
   assign retired_count       = '0;
   assign retired_load_count  = '0;
   assign retired_store_count = '0;
`endif

endmodule
